// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped, write-through cache access controller.
package cache_pkg;

   localparam int unsigned LINES       = 16;
   localparam logic [1:0]  WAIT_CYCLES = 2'd2;

   localparam int unsigned INDEX_LSB = 2;
   localparam int unsigned INDEX_MSB = 5;
   localparam int unsigned TAG_LSB   = 6;
   localparam int unsigned TAG_MSB   = 31;
   localparam int unsigned INDEX_W   = INDEX_MSB - INDEX_LSB + 1;
   localparam int unsigned TAG_W     = TAG_MSB - TAG_LSB + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TAG      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[INDEX_MSB:INDEX_LSB];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[TAG_MSB:TAG_LSB];
   endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: one asynchronous read port, one write port, clear-all of the valid bits.
module cache_line_array #(
   parameter int unsigned LINES = cache_pkg::LINES
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        clear_i,
   input  logic [cache_pkg::INDEX_W-1:0] rd_index_i,
   output logic                        rd_valid_o,
   output logic [cache_pkg::TAG_W-1:0]   rd_tag_o,
   output logic [31:0]                 rd_data_o,
   input  logic                        wr_en_i,
   input  logic [cache_pkg::INDEX_W-1:0] wr_index_i,
   input  logic [cache_pkg::TAG_W-1:0]   wr_tag_i,
   input  logic [31:0]                 wr_data_i
);
   import cache_pkg::*;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // NOTE: tag/data arrays are deliberately not reset; valid_q alone qualifies their contents.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_mem[wr_index_i]  <= wr_tag_i;
         data_mem[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_mem[rd_index_i];
   assign rd_data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/cache_access_ctrl.sv
// Direct-mapped write-through (no write-allocate) cache controller; the wait-state
// counter timing the memory access lives outside and is reached via WaitLoad/WaitValue/WaitCarry.
module cache_access_ctrl #(
   parameter int unsigned LINES       = cache_pkg::LINES,
   parameter logic [1:0]  WAIT_CYCLES = cache_pkg::WAIT_CYCLES
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        CpuReq,
   input  logic        CpuWe,
   input  logic [31:0] CpuAddr,
   input  logic [31:0] CpuWdata,
   output logic [31:0] CpuRdata,
   output logic        CpuReady,
   output logic        CpuBusy,
   input  logic        Invalidate,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWdata,
   input  logic [31:0] MemRdata,
   output logic        WaitLoad,
   output logic [1:0]  WaitValue,
   input  logic        WaitCarry
);
   import cache_pkg::*;

   state_e       state_q, state_d;
   logic [29:0]  waddr_q, waddr_d;
   logic         we_q, we_d;
   logic [31:0]  wdata_q, wdata_d;

   logic [31:0]      req_addr;
   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;
   logic             arr_clear;
   logic             arr_wr_en;
   logic [31:0]      arr_wr_data;

   // Byte-offset bits are ignored by design.
   logic unused_byte_offset;
   assign unused_byte_offset = ^CpuAddr[1:0];

   assign req_addr  = {waddr_q, 2'b00};
   assign hit       = rd_valid && (rd_tag == addr_tag(req_addr));
   assign WaitValue = WAIT_CYCLES;

   cache_line_array #(
      .LINES (LINES)
   ) u_lines (
      .clk_i      (Clk),
      .rst_i      (Rst),
      .clear_i    (arr_clear),
      .rd_index_i (addr_index(req_addr)),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (arr_wr_en),
      .wr_index_i (addr_index(req_addr)),
      .wr_tag_i   (addr_tag(req_addr)),
      .wr_data_i  (arr_wr_data)
   );

   // NOTE: all registers use <= so every one of them samples the same pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge Clk) begin
      waddr_q <= waddr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
   end

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      CpuReady    = 1'b0;
      CpuRdata    = '0;
      CpuBusy     = 1'b1;
      WaitLoad    = 1'b0;
      MemReq      = 1'b0;
      MemWe       = 1'b0;
      MemAddr     = '0;
      MemWdata    = '0;
      arr_clear   = 1'b0;
      arr_wr_en   = 1'b0;
      arr_wr_data = wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            CpuBusy = Invalidate;
            if (Invalidate) begin
               arr_clear = 1'b1;
            end else if (CpuReq) begin
               waddr_d = CpuAddr[31:2];
               we_d    = CpuWe;
               wdata_d = CpuWdata;
               state_d = ST_TAG;
            end
         end
         ST_TAG: begin
            if (!we_q && hit) begin
               CpuReady = 1'b1;
               CpuRdata = rd_data;
               state_d  = ST_IDLE;
            end else begin
               WaitLoad  = 1'b1;
               arr_wr_en = we_q && hit;
               state_d   = ST_MEM_WAIT;
            end
         end
         ST_MEM_WAIT: begin
            MemReq   = 1'b1;
            MemWe    = we_q;
            MemAddr  = req_addr;
            MemWdata = we_q ? wdata_q : '0;
            if (WaitCarry) begin
               CpuReady = 1'b1;
               state_d  = ST_IDLE;
               if (!we_q) begin
                  CpuRdata    = MemRdata;
                  arr_wr_en   = 1'b1;
                  arr_wr_data = MemRdata;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Reset abandons any access in flight: quiet outputs, no fill.
      if (Rst) begin
         CpuReady  = 1'b0;
         CpuRdata  = '0;
         CpuBusy   = 1'b0;
         WaitLoad  = 1'b0;
         MemReq    = 1'b0;
         MemWe     = 1'b0;
         MemAddr   = '0;
         MemWdata  = '0;
         arr_clear = 1'b0;
         arr_wr_en = 1'b0;
      end
   end

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a cache/memory reference model.
module tb_cache_access_ctrl;

   localparam int N = 2;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        CpuReq = 1'b0;
   logic        CpuWe = 1'b0;
   logic [31:0] CpuAddr = '0;
   logic [31:0] CpuWdata = '0;
   logic        Invalidate = 1'b0;
   logic [31:0] MemRdata = '0;
   logic        WaitCarry;
   logic [31:0] CpuRdata, MemAddr, MemWdata;
   logic        CpuReady, CpuBusy, MemReq, MemWe, WaitLoad;
   logic [1:0]  WaitValue;
   logic [100:0] all_outs;

   int total = 0;
   int bad   = 0;

   // External free-running wait-state counter.
   logic [1:0] wcnt = 2'd0;
   always @(posedge Clk) begin
      if (WaitLoad) wcnt <= WaitValue;
      else          wcnt <= wcnt - 2'd1;
   end
   assign WaitCarry = (wcnt == 2'd0);

   assign all_outs = {CpuReady, CpuBusy, MemReq, MemWe, WaitLoad, CpuRdata, MemAddr, MemWdata};

   always #5 Clk = ~Clk;

   cache_access_ctrl dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .CpuReq     (CpuReq),
      .CpuWe      (CpuWe),
      .CpuAddr    (CpuAddr),
      .CpuWdata   (CpuWdata),
      .CpuRdata   (CpuRdata),
      .CpuReady   (CpuReady),
      .CpuBusy    (CpuBusy),
      .Invalidate (Invalidate),
      .MemReq     (MemReq),
      .MemWe      (MemWe),
      .MemAddr    (MemAddr),
      .MemWdata   (MemWdata),
      .MemRdata   (MemRdata),
      .WaitLoad   (WaitLoad),
      .WaitValue  (WaitValue),
      .WaitCarry  (WaitCarry)
   );

   // Reference model: which word each line currently holds, and the backing memory.
   bit          model_valid [16];
   logic [25:0] model_tag   [16];
   logic [31:0] mem [logic [29:0]];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
      return mem[a[31:2]];
   endfunction

   function automatic bit model_hit(input logic [31:0] a);
      return model_valid[a[5:2]] && (model_tag[a[5:2]] == a[31:6]);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input string name);
      bit          exp_hit;
      int          exp_lat, lat, mem_cycles, wl_cycles;
      bit          mem_bad;
      logic [31:0] exp_data, got;
      exp_hit  = model_hit(addr);
      exp_data = mem_word(addr);
      exp_lat  = (!we && exp_hit) ? 2 : N + 3;
      MemRdata = exp_data;
      CpuReq = 1'b1; CpuWe = we; CpuAddr = addr; CpuWdata = wdata;
      #1;
      total++;
      if (CpuBusy !== 1'b0) begin
         bad++; $display("FAIL %s accept_busy got=%b exp=0", name, CpuBusy);
      end
      lat = 0; mem_cycles = 0; wl_cycles = 0; mem_bad = 0; got = '0;
      for (int k = 2; k <= 20; k++) begin
         tick();
         if (k == 2) begin
            CpuReq = 1'b0; CpuWe = 1'b0; CpuAddr = $urandom; CpuWdata = $urandom;
         end
         #1;
         if (WaitLoad) wl_cycles++;
         if (MemReq) begin
            mem_cycles++;
            if (MemWe !== we || MemAddr !== {addr[31:2], 2'b00} || (we && MemWdata !== wdata))
               mem_bad = 1;
         end
         if (CpuReady === 1'b1) begin
            lat = k; got = CpuRdata; break;
         end
      end
      total++;
      if (lat != exp_lat) begin
         bad++; $display("FAIL %s latency got=%0d exp=%0d (0 = timeout)", name, lat, exp_lat);
      end
      total++;
      if (mem_cycles != exp_lat - 2 || mem_bad) begin
         bad++; $display("FAIL %s mem_if cycles=%0d exp=%0d bad_fields=%0d", name, mem_cycles,
                         exp_lat - 2, mem_bad);
      end
      total++;
      if (wl_cycles != ((exp_lat == 2) ? 0 : 1)) begin
         bad++; $display("FAIL %s waitload_pulses got=%0d exp=%0d", name, wl_cycles,
                         (exp_lat == 2) ? 0 : 1);
      end
      if (!we) begin
         total++;
         if (got !== exp_data) begin
            bad++; $display("FAIL %s rdata got=%h exp=%h", name, got, exp_data);
         end
      end
      tick();
      #1;
      total++;
      if (CpuReady !== 1'b0 || CpuRdata !== 32'h0) begin
         bad++; $display("FAIL %s after_ready ready=%b rdata=%h exp 0/0", name, CpuReady, CpuRdata);
      end
      if (we) begin
         mem[addr[31:2]] = wdata;
      end else if (!exp_hit) begin
         model_valid[addr[5:2]] = 1'b1;
         model_tag[addr[5:2]]   = addr[31:6];
      end
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      tick(); tick();
      #1;
      total++;
      if (all_outs !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
      end
      total++;
      if (WaitValue !== 2'(N)) begin
         bad++; $display("FAIL reset_waitvalue got=%0d exp=%0d", WaitValue, N);
      end
      Rst = 1'b0;
      tick();
      #1;
      total++;
      if (CpuBusy !== 1'b0 || CpuReady !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset busy=%b ready=%b exp 0/0", CpuBusy, CpuReady);
      end
      model_clear();
   endtask

   task automatic test_directed();
      mem[30'h10] = 32'hA5A5_0001;
      access(1'b0, 32'h0000_0040, 32'h0, "read40_miss");
      access(1'b0, 32'h0000_0040, 32'h0, "read40_hit");
      access(1'b1, 32'h0000_0040, 32'h1234_5678, "write40");
      access(1'b0, 32'h0000_0040, 32'h0, "read40_after_write");
      access(1'b0, 32'h0000_0080, 32'h0, "read80_conflict");
      access(1'b0, 32'h0000_0040, 32'h0, "read40_evicted");
   endtask

   task automatic test_invalidate();
      access(1'b0, 32'h0000_0080, 32'h0, "read80_fill");
      Invalidate = 1'b1; CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 32'h0000_0080;
      #1;
      total++;
      if (CpuBusy !== 1'b1) begin
         bad++; $display("FAIL inval_busy got=%b exp=1", CpuBusy);
      end
      tick();
      Invalidate = 1'b0; CpuReq = 1'b0;
      model_clear();
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (CpuBusy !== 1'b0 || MemReq !== 1'b0 || CpuReady !== 1'b0) begin
            bad++; $display("FAIL inval_req_ignored busy=%b memreq=%b ready=%b exp 0/0/0",
                            CpuBusy, MemReq, CpuReady);
         end
         tick();
      end
      access(1'b0, 32'h0000_0080, 32'h0, "read80_after_inval");
   endtask

   task automatic test_reset_mem_wait();
      bit seen;
      MemRdata = mem_word(32'h0000_0040);
      CpuReq = 1'b1; CpuWe = 1'b0; CpuAddr = 32'h0000_0040;
      tick();
      CpuReq = 1'b0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (MemReq === 1'b1) begin seen = 1; break; end
         tick();
      end
      total++;
      if (!seen) begin
         bad++; $display("FAIL rst_memwait_reach memreq_seen=%0d exp=1", seen);
      end
      Rst = 1'b1;
      #1;
      total++;
      if (all_outs !== '0 || WaitValue !== 2'(N)) begin
         bad++; $display("FAIL rst_memwait_outputs got=%h wv=%0d exp=0 wv=%0d", all_outs, WaitValue, N);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         total++;
         if (all_outs !== '0) begin
            bad++; $display("FAIL rst_memwait_hold got=%h exp=0", all_outs);
         end
      end
      Rst = 1'b0;
      model_clear();
      tick();
      access(1'b0, 32'h0000_0040, 32'h0, "read40_after_rst");
   endtask

   task automatic test_random();
      logic [1:0]  tsel, lo;
      logic [3:0]  idx;
      logic        we;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            Invalidate = 1'b1;
            tick();
            Invalidate = 1'b0;
            model_clear();
         end
         tsel = 2'($urandom);
         idx  = 4'($urandom);
         lo   = 2'($urandom);
         we   = ($urandom_range(0, 3) == 0);
         access(we, {24'h0, tsel, idx, lo}, $urandom, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_invalidate();
      test_reset_mem_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
